// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the synchronous FIFO.
package fifo_pkg;

   typedef enum logic {STD, FWFT} fifo_mode_e;

   // Pointers carry one extra wrap bit above the storage address.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, no reset on contents.
module fifo_mem #(
   parameter int DataWidth = 8,
   parameter int AddrWidth = 3
) (
   input  logic                 i_clk,
   input  logic                 i_wr_en,
   input  logic [AddrWidth-1:0] i_wr_addr,
   input  logic [DataWidth-1:0] i_wr_data,
   input  logic [AddrWidth-1:0] i_rd_addr,
   output logic [DataWidth-1:0] o_rd_data
);

   localparam int Depth = 1 << AddrWidth;

   logic [DataWidth-1:0] mem [Depth];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DataWidth         = 8,
   parameter int Depth             = 8,
   parameter int AlmostFullThresh  = Depth - 1,
   parameter int AlmostEmptyThresh = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_wr_en,
   input  logic [DataWidth-1:0]   i_wr_data,
   input  logic                   i_rd_en,
   output logic [DataWidth-1:0]   o_rd_data,
   output logic                   o_rd_valid,
   output logic                   o_full,
   output logic                   o_empty,
   output logic                   o_almost_full,
   output logic                   o_almost_empty,
   output logic [$clog2(Depth):0] o_count,
   output logic                   o_overflow,
   output logic                   o_underflow,
   input  logic                   i_clr_flags
);

   localparam int AddrWidth = $clog2(Depth);
   localparam int PtrWidth  = ptr_width(Depth);
   localparam int CntWidth  = count_width(Depth);
   localparam logic [CntWidth-1:0] AfThresh = CntWidth'(AlmostFullThresh);
   localparam logic [CntWidth-1:0] AeThresh = CntWidth'(AlmostEmptyThresh);

`ifdef SYNC_FIFO_FWFT_EN
   localparam fifo_mode_e Mode = FWFT;
`else
   localparam fifo_mode_e Mode = STD;
`endif

   function automatic logic ptr_empty(input logic [PtrWidth-1:0] wp, input logic [PtrWidth-1:0] rp);
      return wp == rp;
   endfunction

   function automatic logic ptr_full(input logic [PtrWidth-1:0] wp, input logic [PtrWidth-1:0] rp);
      return (wp[AddrWidth-1:0] == rp[AddrWidth-1:0]) && (wp[AddrWidth] != rp[AddrWidth]);
   endfunction

   logic [PtrWidth-1:0]  wr_ptr_p0, rd_ptr_p0;
   logic [PtrWidth-1:0]  wr_ptr_p1, rd_ptr_p1;
   logic [CntWidth-1:0]  count_p0;
   logic                 wr_acc_p0, rd_acc_p0;
   logic [DataWidth-1:0] head_data;

   // Stage p0: accept decisions and next pointers from the current registered flags
   always_comb begin
      wr_acc_p0 = i_wr_en && !o_full;
      rd_acc_p0 = i_rd_en && !o_empty;
      wr_ptr_p0 = wr_ptr_p1 + PtrWidth'(wr_acc_p0);
      rd_ptr_p0 = rd_ptr_p1 + PtrWidth'(rd_acc_p0);
      count_p0  = CntWidth'(wr_ptr_p0 - rd_ptr_p0);
   end

   // Stage p1: pointers, occupancy and flags registered together
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_p1      <= '0;
         rd_ptr_p1      <= '0;
         o_count        <= '0;
         o_empty        <= 1'b1;
         o_full         <= 1'b0;
         o_almost_empty <= 1'b1;
         o_almost_full  <= 1'b0;
         o_overflow     <= 1'b0;
         o_underflow    <= 1'b0;
      end else begin
         wr_ptr_p1      <= wr_ptr_p0;
         rd_ptr_p1      <= rd_ptr_p0;
         o_count        <= count_p0;
         o_empty        <= ptr_empty(wr_ptr_p0, rd_ptr_p0);
         o_full         <= ptr_full(wr_ptr_p0, rd_ptr_p0);
         o_almost_empty <= count_p0 <= AeThresh;
         o_almost_full  <= count_p0 >= AfThresh;
         // A new error event wins over a simultaneous clear.
         o_overflow     <= (i_wr_en && o_full)  || (o_overflow  && !i_clr_flags);
         o_underflow    <= (i_rd_en && o_empty) || (o_underflow && !i_clr_flags);
      end
   end

   fifo_mem #(
      .DataWidth (DataWidth),
      .AddrWidth (AddrWidth)
   ) u_mem (
      .i_clk     (i_clk),
      .i_wr_en   (wr_acc_p0),
      .i_wr_addr (wr_ptr_p1[AddrWidth-1:0]),
      .i_wr_data (i_wr_data),
      .i_rd_addr (rd_ptr_p1[AddrWidth-1:0]),
      .o_rd_data (head_data)
   );

   if (Mode == FWFT) begin : g_fwft
      assign o_rd_data  = head_data;
      assign o_rd_valid = !o_empty;
   end else begin : g_std
      // Stage p1: registered read word, valid for the single cycle after the pop
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
         end else begin
            o_rd_valid <= rd_acc_p0;
            if (rd_acc_p0) o_rd_data <= head_data;
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

   localparam int DEPTH = 8;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic       i_wr_en = 1'b0;
   logic [7:0] i_wr_data = '0;
   logic       i_rd_en = 1'b0;
   logic       i_clr_flags = 1'b0;
   logic [7:0] o_rd_data;
   logic       o_rd_valid, o_full, o_empty, o_almost_full, o_almost_empty;
   logic [3:0] o_count;
   logic       o_overflow, o_underflow;

   sync_fifo dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_wr_en        (i_wr_en),
      .i_wr_data      (i_wr_data),
      .i_rd_en        (i_rd_en),
      .o_rd_data      (o_rd_data),
      .o_rd_valid     (o_rd_valid),
      .o_full         (o_full),
      .o_empty        (o_empty),
      .o_almost_full  (o_almost_full),
      .o_almost_empty (o_almost_empty),
      .o_count        (o_count),
      .o_overflow     (o_overflow),
      .o_underflow    (o_underflow),
      .i_clr_flags    (i_clr_flags)
   );

   always #5 i_clk = ~i_clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   logic [7:0] q[$];
   logic       m_ovf = 1'b0, m_unf = 1'b0, m_vld = 1'b0;
   logic [7:0] m_data = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_edge(input logic rst, input logic wr, input logic [7:0] d,
                             input logic rd, input logic clr);
      bit full, empty;
      if (rst) begin
         q.delete();
         m_ovf = 0; m_unf = 0; m_vld = 0; m_data = '0;
      end else begin
         full  = (q.size() == DEPTH);
         empty = (q.size() == 0);
         if (clr) begin m_ovf = 0; m_unf = 0; end
         if (wr && full) m_ovf = 1;
         if (rd && empty) m_unf = 1;
         m_vld = rd && !empty;
         if (rd && !empty) m_data = q.pop_front();
         if (wr && !full) q.push_back(d);
      end
   endtask

   task automatic compare_all();
      int n;
      n = q.size();
      check("count",     {28'd0, o_count}, n);
      check("full",      o_full,          n == DEPTH);
      check("empty",     o_empty,         n == 0);
      check("alm_full",  o_almost_full,   n >= DEPTH - 1);
      check("alm_empty", o_almost_empty,  n <= 1);
      check("overflow",  o_overflow,      m_ovf);
      check("underflow", o_underflow,     m_unf);
`ifdef SYNC_FIFO_FWFT_EN
      check("rd_valid",  o_rd_valid,      n != 0);
      if (n != 0) check("rd_data", o_rd_data, q[0]);
`else
      check("rd_valid",  o_rd_valid,      m_vld);
      check("rd_data",   o_rd_data,       m_data);
`endif
   endtask

   task automatic step(input logic rst, input logic wr, input logic [7:0] d,
                       input logic rd, input logic clr);
      i_rst = rst; i_wr_en = wr; i_wr_data = d; i_rd_en = rd; i_clr_flags = clr;
      @(posedge i_clk);
      model_edge(rst, wr, d, rd, clr);
      #1;
      compare_all();
   endtask

   initial begin
      logic [7:0] first;
      @(posedge i_clk); #1;

      // Reset state
      step(1, 0, 8'h00, 0, 0);
      check("rst_empty", o_empty, 1);
      check("rst_count", {28'd0, o_count}, 0);

      // Fill with 0x10..0x17, then one write too many
      for (int i = 0; i < 8; i++) step(0, 1, 8'h10 + 8'(i), 0, 0);
      check("fill_full", o_full, 1);
      check("fill_count", {28'd0, o_count}, 8);
      step(0, 1, 8'h99, 0, 0);
      check("ovf_set", o_overflow, 1);
      check("ovf_count", {28'd0, o_count}, 8);

      // Drain in order, then one read too many
      for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         check("fwft_head", o_rd_data, 8'h10 + 8'(i));
         step(0, 0, 8'h00, 1, 0);
`else
         step(0, 0, 8'h00, 1, 0);
         check("rd_order", o_rd_data, 8'h10 + 8'(i));
         check("rd_pulse", o_rd_valid, 1);
`endif
      end
      check("drain_empty", o_empty, 1);
      step(0, 0, 8'h00, 1, 0);
      check("unf_set", o_underflow, 1);
      step(0, 0, 8'h00, 0, 1);
      check("clr_ovf", o_overflow, 0);
      check("clr_unf", o_underflow, 0);

      // Steady state at count 4 across two pointer wraps
      for (int i = 0; i < 4; i++) step(0, 1, 8'h40 + 8'(i), 0, 0);
      for (int i = 0; i < 20; i++) begin
         step(0, 1, 8'h80 + 8'(i), 1, 0);
         check("steady_cnt", {28'd0, o_count}, 4);
      end
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);

      // Simultaneous write/read at empty and at full
      step(0, 1, 8'hA0, 1, 0);
      check("sim_empty_cnt", {28'd0, o_count}, 1);
      check("sim_empty_unf", o_underflow, 1);
      for (int i = 1; i < 8; i++) step(0, 1, 8'hA0 + 8'(i), 0, 0);
      check("pre_sim_full", o_full, 1);
      step(0, 1, 8'hEE, 1, 0);
      check("sim_full_cnt", {28'd0, o_count}, 7);
      check("sim_full_ovf", o_overflow, 1);
      check("af_at7", o_almost_full, 1);
      for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0);
      check("ae_at1", o_almost_empty, 1);
      check("ae_cnt1", {28'd0, o_count}, 1);
      step(0, 0, 8'h00, 0, 1);
      check("clr_both", {30'd0, o_overflow, o_underflow}, 0);

      // Set wins over clear
      step(0, 0, 8'h00, 1, 0);
      step(0, 0, 8'h00, 1, 1);
      check("set_over_clr", o_underflow, 1);
      step(0, 0, 8'h00, 0, 1);

      // Reset mid-stream at count 5 discards old entries
      for (int i = 0; i < 5; i++) step(0, 1, 8'h30 + 8'(i), 0, 0);
      check("pre_rst_cnt", {28'd0, o_count}, 5);
      step(1, 1, 8'h77, 1, 0);
      check("mid_rst_cnt", {28'd0, o_count}, 0);
      check("mid_rst_empty", o_empty, 1);
      step(0, 1, 8'h5A, 0, 0);
      first = 8'h5A;
`ifdef SYNC_FIFO_FWFT_EN
      check("post_rst_data", o_rd_data, first);
      step(0, 0, 8'h00, 1, 0);
`else
      step(0, 0, 8'h00, 1, 0);
      check("post_rst_data", o_rd_data, first);
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 55,
              8'($urandom),
              $urandom_range(0, 99) < 50,
              $urandom_range(0, 99) < 5);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DataWidth, default 8, word width in bits.
REQ-002 SHALL have parameter Depth, default 8, entry count; power of two, >=2.
REQ-003 SHALL have parameter AlmostFullThresh, default Depth-1, count at or above which o_almost_full asserts.
REQ-004 SHALL have parameter AlmostEmptyThresh, default 1, count at or below which o_almost_empty asserts.
REQ-005 SHALL use one clock and a synchronous, active-high reset; ports are listed below, clock and reset first.
REQ-006 SHALL have port i_clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports i_wr_en (input, 1, write request) and i_wr_data (input, DataWidth, write word).
REQ-009 SHALL have ports i_rd_en (input, 1, read request), o_rd_data (output, DataWidth, read word) and o_rd_valid (output, 1, o_rd_data valid).
REQ-010 SHALL have ports o_full, o_empty, o_almost_full and o_almost_empty (each output, 1, status flags).
REQ-011 SHALL have port o_count, output, $clog2(Depth)+1, current occupancy 0..Depth.
REQ-012 SHALL have ports o_overflow and o_underflow (each output, 1, sticky error flags) and i_clr_flags (input, 1, clears both).

Function
REQ-013 SHALL keep write/read pointers of AddrWidth+1 bits; low AddrWidth bits address storage, MSB is the wrap bit.
REQ-014 SHALL define empty as pointers equal, and full as low bits equal with MSBs different.
REQ-015 SHALL accept a write iff i_wr_en && !o_full; accepted write stores the word and increments the write pointer, wrapping Depth-1 -> 0.
REQ-016 SHALL accept a read iff i_rd_en && !o_empty; accepted read increments the read pointer with the same wrap rule.
REQ-017 SHALL, on simultaneous accepted read and write, leave o_count unchanged; when full, the read is accepted and the write rejected; when empty, the write is accepted and the read rejected.
REQ-018 SHALL update o_count, o_full, o_empty, o_almost_full and o_almost_empty as registered values one cycle after the accepting edge.
REQ-019 SHALL set o_overflow on i_wr_en && o_full, and set o_underflow on i_rd_en && o_empty; both hold until i_clr_flags or i_rst.
REQ-020 SHALL give set priority over clear when an error event and i_clr_flags coincide.
REQ-021 SHALL, in standard mode, register o_rd_data from the head entry on an accepted read and pulse o_rd_valid high for exactly one cycle; o_rd_data holds its value otherwise.

Reset
REQ-022 SHALL, on i_rst, set both pointers and o_count to 0, o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_rd_valid=0, o_rd_data=0, o_overflow=0 and o_underflow=0.
REQ-023 SHALL give i_rst priority over all other inputs in the same cycle; storage contents are not reset, and entries written before reset are discarded.

Configuration
REQ-024 SHALL, with macro SYNC_FIFO_FWFT_EN defined, operate first-word-fall-through: o_rd_data shows the head entry combinationally, o_rd_valid = !o_empty, and i_rd_en pops the head.
REQ-025 SHALL, without SYNC_FIFO_FWFT_EN, operate in the standard registered-read mode of REQ-021.

Structure
REQ-026 SHALL place the pointer and count width helper functions and the mode enum (STD, FWFT) in package fifo_pkg.
REQ-027 SHALL instantiate storage as sub-module fifo_mem: dual-port, async read, sync write, no reset.

Verification
REQ-028 SHALL cover: reset, then 8 writes of 0x10..0x17 -> o_full=1 and o_count=8; 9th write -> o_overflow=1 and contents unchanged.
REQ-029 SHALL cover: 8 reads after the fill -> data 0x10..0x17 in order (standard mode valid 1 cycle after each read), then o_empty=1; extra read -> o_underflow=1.
REQ-030 SHALL cover: 20 write+read cycles at count 4 -> o_count stays 4, pointers wrap twice and data order is preserved.
REQ-031 SHALL cover: simultaneous wr/rd when empty -> count 0 -> 1, o_underflow=1; when full -> count 8 -> 7, o_overflow=1.
REQ-032 SHALL cover: count at 7 -> o_almost_full=1; count at 1 -> o_almost_empty=1; i_clr_flags clears sticky flags in one cycle.
REQ-033 SHALL cover: i_rst asserted mid-stream with count 5 -> next cycle count 0, o_empty=1, and the next read returns a newly written word only.
